// File: rtl/krnl_cam_arb_pkg.sv
// Shared types and the round-robin pick helper for the CAM request arbiter.
package krnl_cam_arb_pkg;

  localparam int unsigned MaxReq  = 8;
  localparam int unsigned MaxReqW = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} arb_state_t;

  typedef struct packed {
    logic               found;
    logic [MaxReqW-1:0] idx;
  } rr_pick_t;

  // First valid index after ptr, wrapping at num (num <= MaxReq).
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0]  valid,
                                       input logic [MaxReqW-1:0] ptr,
                                       input int unsigned        num);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      cand = (32'(ptr) + k) % num;
      if (k <= num && !res.found && valid[MaxReqW'(cand)]) begin
        res.found = 1'b1;
        res.idx   = MaxReqW'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/krnl_cam_arb_tag_fifo.sv
// First-word-fall-through FIFO of grant indices; pointers carry an extra wrap bit.
module krnl_cam_arb_tag_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign dout_o  = mem_q[rptr_q[AddrW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AddrW-1:0]] <= din_i;
  end

endmodule

// File: rtl/krnl_cam_req_arbiter.sv
// Round-robin sharing of one in-order CAM pipeline among NUM_REQ stream requesters,
// with tag-FIFO response routing, credit limiting and a run/drain control FSM.
module krnl_cam_req_arbiter
  import krnl_cam_arb_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH    = 512,
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              ctrl_start,
  input  logic                              ctrl_drain,
  output logic                              ctrl_idle,
  output logic                              ctrl_done,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]   req_TDATA,
  input  logic [NUM_REQ-1:0]                req_TVALID,
  output logic [NUM_REQ-1:0]                req_TREADY,
  output logic [C_DATA_WIDTH-1:0]           cam_TDATA,
  output logic                              cam_TVALID,
  input  logic                              cam_TREADY,
  input  logic [C_DATA_WIDTH-1:0]           res_TDATA,
  input  logic                              res_TVALID,
  output logic                              res_TREADY,
  output logic [NUM_REQ*C_DATA_WIDTH-1:0]   rsp_TDATA,
  output logic [NUM_REQ-1:0]                rsp_TVALID,
  input  logic [NUM_REQ-1:0]                rsp_TREADY,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                              err_orphan
);

  localparam int unsigned TagW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t              state_q, state_d;
  logic                    cam_valid_q, cam_valid_d;
  logic [C_DATA_WIDTH-1:0] cam_data_q, cam_data_d;
  logic [CntW-1:0]         out_q, out_d;
  logic [TagW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;

  logic [MaxReq-1:0] valid_ext;
  rr_pick_t          pick;
  logic [TagW-1:0]   grant;
  logic              slot_free, credit_ok, issue;
  logic              cam_hs, res_hs;
  logic [TagW-1:0]   tag_head;
  logic              fifo_empty, fifo_full;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = req_TVALID;
  end

  assign pick      = rr_pick(valid_ext, MaxReqW'(rr_ptr_q), NUM_REQ);
  assign grant     = TagW'(pick.idx);
  assign slot_free = ~cam_valid_q | cam_TREADY;
  // The staged beat already holds a tag, so it consumes a credit too.
  assign credit_ok = (32'(out_q) + 32'(cam_valid_q)) < MAX_OUTSTANDING;
  assign issue     = (state_q == ST_RUN) & slot_free & credit_ok & pick.found & ~fifo_full;
  assign cam_hs    = cam_valid_q & cam_TREADY;

  always_comb begin
    req_TREADY = '0;
    if (issue) req_TREADY[grant] = 1'b1;
  end

  // Responses with no pending tag are swallowed and flagged.
  always_comb begin
    rsp_TVALID = '0;
    res_TREADY = 1'b1;
    if (!fifo_empty) begin
      rsp_TVALID[tag_head] = res_TVALID;
      res_TREADY           = rsp_TREADY[tag_head];
    end
  end

  assign res_hs    = res_TVALID & res_TREADY & ~fifo_empty;
  assign rsp_TDATA = {NUM_REQ{res_TDATA}};

  krnl_cam_arb_tag_fifo #(
    .Width (TagW),
    .Depth (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .push_i  (issue),
    .pop_i   (res_hs),
    .din_i   (grant),
    .dout_o  (tag_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    cam_valid_d = cam_valid_q & ~cam_TREADY;
    cam_data_d  = cam_data_q;
    rr_ptr_d    = rr_ptr_q;
    out_d       = out_q + CntW'(cam_hs) - CntW'(res_hs);
    err_d       = err_q | (res_TVALID & fifo_empty);

    unique case (state_q)
      ST_IDLE:  if (ctrl_start) state_d = ST_RUN;
      ST_RUN:   if (ctrl_drain) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (out_q == '0 && !cam_valid_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    if (issue) begin
      cam_valid_d = 1'b1;
      cam_data_d  = req_TDATA[int'(grant)*C_DATA_WIDTH +: C_DATA_WIDTH];
      rr_ptr_d    = grant;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      cam_valid_q <= 1'b0;
      cam_data_q  <= '0;
      out_q       <= '0;
      rr_ptr_q    <= TagW'(NUM_REQ - 1);
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cam_valid_q <= cam_valid_d;
      cam_data_q  <= cam_data_d;
      out_q       <= out_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign cam_TVALID  = cam_valid_q;
  assign cam_TDATA   = cam_data_q;
  assign outstanding = out_q;
  assign err_orphan  = err_q;
  assign ctrl_idle   = (state_q == ST_IDLE);
  assign ctrl_done   = done_q;

endmodule

// File: tb/tb_krnl_cam_req_arbiter.sv
// Bench for krnl_cam_req_arbiter: directed phases plus random traffic against a queue-based model.
module tb_krnl_cam_req_arbiter;

  localparam int W  = 512;
  localparam int N  = 4;
  localparam int M  = 16;
  localparam int CW = $clog2(M + 1);

  logic           ap_clk = 1'b0;
  logic           ap_rst_n;
  logic           ctrl_start, ctrl_drain, ctrl_idle, ctrl_done;
  logic [N*W-1:0] req_TDATA;
  logic [N-1:0]   req_TVALID, req_TREADY;
  logic [W-1:0]   cam_TDATA;
  logic           cam_TVALID, cam_TREADY;
  logic [W-1:0]   res_TDATA;
  logic           res_TVALID, res_TREADY;
  logic [N*W-1:0] rsp_TDATA;
  logic [N-1:0]   rsp_TVALID, rsp_TREADY;
  logic [CW-1:0]  outstanding;
  logic           err_orphan;

  always #5 ap_clk = ~ap_clk;

  krnl_cam_req_arbiter #(
    .C_DATA_WIDTH    (W),
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (M)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ctrl_start  (ctrl_start),
    .ctrl_drain  (ctrl_drain),
    .ctrl_idle   (ctrl_idle),
    .ctrl_done   (ctrl_done),
    .req_TDATA   (req_TDATA),
    .req_TVALID  (req_TVALID),
    .req_TREADY  (req_TREADY),
    .cam_TDATA   (cam_TDATA),
    .cam_TVALID  (cam_TVALID),
    .cam_TREADY  (cam_TREADY),
    .res_TDATA   (res_TDATA),
    .res_TVALID  (res_TVALID),
    .res_TREADY  (res_TREADY),
    .rsp_TDATA   (rsp_TDATA),
    .rsp_TVALID  (rsp_TVALID),
    .rsp_TREADY  (rsp_TREADY),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  typedef struct {
    logic [W-1:0] data;
    int           owner;
  } beat_t;

  // Model: staged beat, issued-not-answered beats in order, and the CAM's own pipeline.
  beat_t        issue_q[$];
  beat_t        owner_q[$];
  logic [W-1:0] cam_pipe[$];
  int           m_state;  // 0 idle, 1 run, 2 drain
  int           m_rr, m_out;
  bit           m_err, m_done;

  logic [W-1:0] req_data [N];
  logic [N-1:0] req_v, rsp_rdy;
  bit           cam_rdy, res_en;
  int           total, bad, seq;
  int           grant_log[$];
  int           n_cam_hs, n_res_hs, n_done;

  function automatic logic [W-1:0] new_data(input int id);
    logic [W-1:0] d;
    seq++;
    d            = '0;
    d[W-1:W-32]  = $urandom;
    d[63:32]     = $urandom;
    d[31:8]      = 24'(seq);
    d[7:0]       = 8'(id);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    issue_q.delete();
    owner_q.delete();
    m_state = 0;
    m_rr    = N - 1;
    m_out   = 0;
    m_err   = 0;
    m_done  = 0;
  endtask

  task automatic drive();
    req_TVALID = req_v;
    cam_TREADY = cam_rdy;
    rsp_TREADY = rsp_rdy;
    for (int i = 0; i < N; i++) req_TDATA[i*W +: W] = req_data[i];
    res_TVALID = res_en && (cam_pipe.size() > 0);
    res_TDATA  = (cam_pipe.size() > 0) ? cam_pipe[0] : '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model and DUT, check registers.
  task automatic tick();
    logic [N-1:0] exp_ready, exp_rsp_valid;
    bit           exp_res_ready, staged, cam_hs_m, res_hs_m, has_head, done_next;
    int           g, head, next_state;
    beat_t        b;

    drive();
    #2;
    staged    = issue_q.size() > 0;
    exp_ready = '0;
    g         = -1;
    if (m_state == 1 && (!staged || cam_rdy) && (m_out + issue_q.size() < M)) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && req_v[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    has_head      = owner_q.size() > 0;
    head          = has_head ? owner_q[0].owner : 0;
    exp_rsp_valid = '0;
    exp_res_ready = 1'b1;
    if (has_head) begin
      exp_rsp_valid[head] = res_TVALID;
      exp_res_ready       = rsp_rdy[head];
    end

    chk("req_ready", W'(req_TREADY), W'(exp_ready));
    chk("cam_valid", W'(cam_TVALID), W'(staged));
    if (staged) chk("cam_data", cam_TDATA, issue_q[0].data);
    chk("res_ready", W'(res_TREADY), W'(exp_res_ready));
    chk("rsp_valid", W'(rsp_TVALID), W'(exp_rsp_valid));

    cam_hs_m = staged && cam_rdy;
    res_hs_m = res_TVALID && exp_res_ready;
    if (res_hs_m && has_head) chk("rsp_data", rsp_TDATA[head*W +: W], owner_q[0].data);

    if (cam_TVALID && cam_TREADY) n_cam_hs++;
    if (res_TVALID && res_TREADY) n_res_hs++;
    for (int i = 0; i < N; i++) if (req_TREADY[i] && req_TVALID[i]) grant_log.push_back(i);

    next_state = m_state;
    done_next  = 0;
    if (m_state == 0 && ctrl_start) next_state = 1;
    else if (m_state == 1 && ctrl_drain) next_state = 2;
    else if (m_state == 2 && m_out == 0 && !staged) begin
      next_state = 0;
      done_next  = 1;
    end

    @(posedge ap_clk);
    #1;
    if (res_hs_m) begin
      void'(cam_pipe.pop_front());
      if (has_head) begin
        void'(owner_q.pop_front());
        m_out--;
      end else begin
        m_err = 1;
      end
    end
    if (cam_hs_m) begin
      cam_pipe.push_back(issue_q[0].data);
      void'(issue_q.pop_front());
      m_out++;
    end
    if (g >= 0) begin
      b.data  = req_data[g];
      b.owner = g;
      issue_q.push_back(b);
      owner_q.push_back(b);
      m_rr        = g;
      req_data[g] = new_data(g);
    end
    m_state = next_state;
    m_done  = done_next;

    chk("outstanding", W'(outstanding), W'(m_out));
    chk("ctrl_idle", W'(ctrl_idle), W'(m_state == 0));
    chk("ctrl_done", W'(ctrl_done), W'(m_done));
    chk("err_orphan", W'(err_orphan), W'(m_err));
    if (ctrl_done) n_done++;
  endtask

  initial begin
    total = 0; bad = 0; seq = 0;
    n_cam_hs = 0; n_res_hs = 0; n_done = 0;
    for (int i = 0; i < N; i++) req_data[i] = new_data(i);
    req_v = '1; rsp_rdy = '1; cam_rdy = 1; res_en = 0;
    ctrl_start = 0; ctrl_drain = 0; ap_rst_n = 0;
    model_reset();
    drive();

    // Reset held with every requester valid
    repeat (3) @(posedge ap_clk);
    #1;
    drive();
    #1;
    chk("rst_req_ready", W'(req_TREADY), '0);
    chk("rst_cam_valid", W'(cam_TVALID), '0);
    chk("rst_cam_data", cam_TDATA, '0);
    chk("rst_outstanding", W'(outstanding), '0);
    chk("rst_idle", W'(ctrl_idle), W'(1));
    chk("rst_done", W'(ctrl_done), '0);
    chk("rst_orphan", W'(err_orphan), '0);
    ap_rst_n = 1;

    // Fairness: all valid, CAM always ready and echoing
    ctrl_start = 1; tick(); ctrl_start = 0;
    req_v = '1; res_en = 1; grant_log.delete();
    repeat (12) tick();
    chk("fair_grant_count", W'(grant_log.size()), W'(12));
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("fair_grant_order", W'(grant_log[k]), W'(k % 4));
    req_v = '0;
    repeat (4) tick();

    // Credits: no responses, exactly M issues reach the CAM
    res_en = 0; req_v = '1; n_cam_hs = 0;
    repeat (24) tick();
    chk("credit_cam_hs", W'(n_cam_hs), W'(M));
    chk("credit_block", W'(req_TREADY), '0);
    res_en = 1; tick(); res_en = 0;
    n_cam_hs = 0;
    repeat (4) tick();
    chk("credit_one_issue", W'(n_cam_hs), W'(1));
    req_v = '0; res_en = 1;
    repeat (24) tick();

    // Backpressure: tag-2 beat in the CAM, then 0xA5 staged while CAM stalls
    res_en = 0; req_v = 4'b0100; tick(); req_v = '0; tick();
    req_data[1] = W'('hA5); req_v = 4'b0010; cam_rdy = 0; tick(); req_v = '0;
    repeat (5) begin
      tick();
      chk("bp_cam_data", cam_TDATA, W'('hA5));
    end
    rsp_rdy = 4'b1011; res_en = 1;
    repeat (3) begin
      tick();
      chk("bp_res_stall", W'(res_TREADY), '0);
      chk("bp_rsp_valid", W'(rsp_TVALID), W'(4'b0100));
    end
    rsp_rdy = '1; cam_rdy = 1;
    repeat (6) tick();

    // Drain with 7 in flight
    res_en = 0;
    for (int k = 0; k < 7; k++) begin
      req_v = N'(1 << (k % N));
      tick();
    end
    req_v = '0;
    repeat (2) tick();
    chk("drain_inflight", W'(outstanding), W'(7));
    ctrl_drain = 1; tick(); ctrl_drain = 0;
    req_v = '1; res_en = 1; n_done = 0; grant_log.delete();
    repeat (12) tick();
    chk("drain_no_grants", W'(grant_log.size()), '0);
    chk("drain_done_pulses", W'(n_done), W'(1));
    chk("drain_idle", W'(ctrl_idle), W'(1));

    // Random traffic
    ctrl_start = 1; tick(); ctrl_start = 0;
    repeat (400) begin
      req_v   = N'($urandom);
      cam_rdy = ($urandom % 4) != 0;
      rsp_rdy = N'($urandom);
      res_en  = ($urandom % 3) != 0;
      tick();
    end
    req_v = '0; cam_rdy = 1; rsp_rdy = '1; res_en = 1;
    ctrl_drain = 1; tick(); ctrl_drain = 0;
    repeat (40) tick();
    chk("rand_idle", W'(ctrl_idle), W'(1));

    // Reset with 3 in flight; their responses become orphans
    ctrl_start = 1; tick(); ctrl_start = 0;
    res_en = 0;
    for (int k = 0; k < 3; k++) begin
      req_v = N'(1 << k);
      tick();
    end
    req_v = '0;
    repeat (2) tick();
    ap_rst_n = 0;
    drive();
    repeat (2) @(posedge ap_clk);
    #1;
    model_reset();
    ap_rst_n = 1;
    rsp_rdy = '0; res_en = 1; n_res_hs = 0;
    repeat (5) tick();
    chk("orphan_drained", W'(n_res_hs), W'(3));
    chk("orphan_flag", W'(err_orphan), W'(1));
    chk("orphan_outstanding", W'(outstanding), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
